// File: rtl/gray_codec_pipe_if.sv
// Valid/ready stream bundle for gray_codec_pipe: input word channel, converted
// word channel and the step-error counter.
interface gray_codec_pipe_if #(
   parameter int unsigned WIDTH     = 4,
   parameter int unsigned ERR_CNT_W = 8
);
   logic                 in_valid;
   logic                 in_ready;
   logic                 in_mode;
   logic [WIDTH-1:0]     in_data;
   logic                 out_valid;
   logic                 out_ready;
   logic                 out_mode;
   logic [WIDTH-1:0]     out_data;
   logic                 out_step_err;
   logic [ERR_CNT_W-1:0] err_count;

   modport master (
      output in_valid, in_mode, in_data, out_ready,
      input  in_ready, out_valid, out_mode, out_data, out_step_err, err_count
   );

   modport slave (
      input  in_valid, in_mode, in_data, out_ready,
      output in_ready, out_valid, out_mode, out_data, out_step_err, err_count
   );
endinterface

// File: rtl/gray_codec_pipe.sv
// Registered bidirectional binary/Gray converter with a one-stage valid/ready
// output register and a saturating counter of illegal Gray input steps.
module gray_codec_pipe #(
   parameter int unsigned WIDTH     = 4,
   parameter int unsigned ERR_CNT_W = 8
) (
   input logic             clk,
   input logic             rst_n,
   gray_codec_pipe_if.slave bus
);
   localparam logic [ERR_CNT_W-1:0] ErrMax = '1;

   logic                 out_valid_q, out_valid_d;
   logic                 out_mode_q, out_mode_d;
   logic                 out_err_q, out_err_d;
   logic [WIDTH-1:0]     out_data_q, out_data_d;
   logic [WIDTH-1:0]     hist_q, hist_d;
   logic                 hist_vld_q, hist_vld_d;
   logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

   logic                 accept;
   logic                 step_err;
   logic [WIDTH-1:0]     gray;
   logic [WIDTH-1:0]     bin;

   assign bus.in_ready = !out_valid_q || bus.out_ready;
   assign accept       = bus.in_valid && bus.in_ready;

   always_comb begin
      gray = bus.in_data ^ (bus.in_data >> 1);
   end

   // Each binary bit is the XOR of all Gray bits at or above it.
   always_comb begin
      bin = '0;
      for (int i = 0; i < int'(WIDTH); i++) begin
         bin[i] = ^(bus.in_data >> i);
      end
   end

   // Distance 0 (repeated code) is illegal as well as distance > 1.
   assign step_err = bus.in_mode && hist_vld_q && ($countones(bus.in_data ^ hist_q) != 1);

   always_comb begin
      out_valid_d = out_valid_q;
      out_mode_d  = out_mode_q;
      out_err_d   = out_err_q;
      out_data_d  = out_data_q;
      hist_d      = hist_q;
      hist_vld_d  = hist_vld_q;
      err_cnt_d   = err_cnt_q;
      if (accept) begin
         out_valid_d = 1'b1;
         out_mode_d  = bus.in_mode;
         out_data_d  = bus.in_mode ? bin : gray;
         out_err_d   = step_err;
         if (bus.in_mode) begin
            hist_d     = bus.in_data;
            hist_vld_d = 1'b1;
         end
         if (step_err && (err_cnt_q != ErrMax)) begin
            err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
         end
      end else if (out_valid_q && bus.out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_mode_q  <= 1'b0;
         out_err_q   <= 1'b0;
         out_data_q  <= '0;
         hist_q      <= '0;
         hist_vld_q  <= 1'b0;
         err_cnt_q   <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_mode_q  <= out_mode_d;
         out_err_q   <= out_err_d;
         out_data_q  <= out_data_d;
         hist_q      <= hist_d;
         hist_vld_q  <= hist_vld_d;
         err_cnt_q   <= err_cnt_d;
      end
   end

   assign bus.out_valid    = out_valid_q;
   assign bus.out_mode     = out_mode_q;
   assign bus.out_data     = out_data_q;
   assign bus.out_step_err = out_err_q;
   assign bus.err_count    = err_cnt_q;
endmodule

// File: tb/tb_gray_codec_pipe.sv
// Bench for gray_codec_pipe: directed vectors with literal expectations plus a
// per-cycle comparison against an arithmetic reference model.
module tb_gray_codec_pipe;
   localparam int unsigned W = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   gray_codec_pipe_if #(.WIDTH(W), .ERR_CNT_W(8)) bus ();
   gray_codec_pipe_if #(.WIDTH(W), .ERR_CNT_W(2)) bus2 ();

   gray_codec_pipe #(.WIDTH(W), .ERR_CNT_W(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   gray_codec_pipe #(.WIDTH(W), .ERR_CNT_W(2)) dut_sat (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus2.slave)
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   function automatic int popcnt(input logic [W-1:0] v);
      int n = 0;
      for (int i = 0; i < int'(W); i++) n += int'(v[i]);
      return n;
   endfunction

   function automatic logic [W-1:0] from_gray(input logic [W-1:0] g);
      logic [W-1:0] b = '0;
      for (int k = 0; k < int'(W); k++) b ^= g >> k;
      return b;
   endfunction

   // Reference model: expected contents of the output stage and error history.
   logic         started = 1'b0;
   logic         m_valid = 1'b0;
   logic         m_mode = 1'b0;
   logic         m_err = 1'b0;
   logic [W-1:0] m_data = '0;
   logic [W-1:0] m_hist = '0;
   logic         m_hvld = 1'b0;
   int           m_raw = 0;
   logic         m_acc;
   logic         m_step;

   assign m_acc  = bus.in_valid && (!m_valid || bus.out_ready);
   assign m_step = bus.in_mode && m_hvld && (popcnt(bus.in_data ^ m_hist) != 1);

   always @(posedge clk) begin
      if (!rst_n) begin
         started <= 1'b1;
         m_valid <= 1'b0;
         m_mode  <= 1'b0;
         m_err   <= 1'b0;
         m_data  <= '0;
         m_hist  <= '0;
         m_hvld  <= 1'b0;
         m_raw   <= 0;
      end else if (started) begin
         if (m_acc) begin
            m_valid <= 1'b1;
            m_mode  <= bus.in_mode;
            m_err   <= m_step;
            m_data  <= bus.in_mode ? from_gray(bus.in_data) : (bus.in_data ^ (bus.in_data >> 1));
            if (bus.in_mode) begin
               m_hist <= bus.in_data;
               m_hvld <= 1'b1;
            end
            if (m_step) m_raw <= m_raw + 1;
         end else if (m_valid && bus.out_ready) begin
            m_valid <= 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      if (started) begin
         check("mdl_in_ready", 32'(bus.in_ready), 32'(!m_valid || bus.out_ready));
         check("mdl_out_valid", 32'(bus.out_valid), 32'(m_valid));
         check("mdl_err_count", 32'(bus.err_count), 32'((m_raw > 255) ? 255 : m_raw));
         check("mdl_err_count_sat", 32'(bus2.err_count), 32'((m_raw > 3) ? 3 : m_raw));
         if (m_valid) begin
            check("mdl_out_data", 32'(bus.out_data), 32'(m_data));
            check("mdl_out_mode", 32'(bus.out_mode), 32'(m_mode));
            check("mdl_out_step_err", 32'(bus.out_step_err), 32'(m_err));
         end
      end
   end

   task automatic drive(input logic v, input logic m, input logic [W-1:0] d, input logic r);
      bus.in_valid   = v;
      bus.in_mode    = m;
      bus.in_data    = d;
      bus.out_ready  = r;
      bus2.in_valid  = v;
      bus2.in_mode   = m;
      bus2.in_data   = d;
      bus2.out_ready = r;
   endtask

   task automatic sync();
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      drive(1'b0, 1'b0, '0, 1'b1);
      sync();
      rst_n = 1'b1;
   endtask

   // One accepted word with out_ready high; checks the word the next cycle.
   task automatic xfer(input logic m, input logic [W-1:0] d, input logic [W-1:0] exp_d,
                       input logic exp_err, input int exp_cnt);
      drive(1'b1, m, d, 1'b1);
      sync();
      drive(1'b0, 1'b0, '0, 1'b1);
      @(negedge clk);
      check("xfer_valid", 32'(bus.out_valid), 32'd1);
      check("xfer_data", 32'(bus.out_data), 32'(exp_d));
      check("xfer_step_err", 32'(bus.out_step_err), 32'(exp_err));
      if (exp_cnt >= 0) check("xfer_err_count", 32'(bus.err_count), 32'(exp_cnt));
      sync();
   endtask

   initial begin
      drive(1'b0, 1'b0, '0, 1'b1);
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_out_data", 32'(bus.out_data), 32'd0);
      check("rst_err_count", 32'(bus.err_count), 32'd0);
      check("rst_in_ready", 32'(bus.in_ready), 32'd1);
      sync();

      xfer(1'b0, 4'b1011, 4'b1110, 1'b0, 0);

      // Consecutive Gray codes are distance 1, so the round trip never flags.
      do_reset();
      for (int b = 0; b < 16; b++) begin
         xfer(1'b0, W'(b), W'(b ^ (b >> 1)), 1'b0, 0);
         xfer(1'b1, W'(b ^ (b >> 1)), W'(b), 1'b0, 0);
      end
      xfer(1'b1, 4'b0000, 4'b0000, 1'b0, 0);

      do_reset();
      xfer(1'b1, 4'b1110, 4'b1011, 1'b0, 0);

      do_reset();
      xfer(1'b1, 4'b0000, 4'b0000, 1'b0, 0);
      xfer(1'b1, 4'b0001, 4'b0001, 1'b0, 0);
      xfer(1'b1, 4'b0011, 4'b0010, 1'b0, 0);
      xfer(1'b1, 4'b0010, 4'b0011, 1'b0, 0);

      do_reset();
      xfer(1'b1, 4'b0000, 4'b0000, 1'b0, 0);
      xfer(1'b1, 4'b0011, 4'b0010, 1'b1, 1);
      xfer(1'b1, 4'b0011, 4'b0010, 1'b1, 2);
      xfer(1'b0, 4'b0110, 4'b0101, 1'b0, 2);
      xfer(1'b1, 4'b0001, 4'b0001, 1'b0, 2);

      // Backpressure: word A held for 5 cycles, then B and C back to back.
      drive(1'b1, 1'b0, 4'b0011, 1'b0);
      sync();
      drive(1'b1, 1'b0, 4'b0101, 1'b0);
      repeat (5) begin
         @(negedge clk);
         check("stall_in_ready", 32'(bus.in_ready), 32'd0);
         check("stall_data", 32'(bus.out_data), 32'(4'b0010));
         sync();
      end
      drive(1'b1, 1'b0, 4'b0101, 1'b1);
      sync();
      drive(1'b1, 1'b0, 4'b1001, 1'b1);
      @(negedge clk);
      check("b2b_data_b", 32'(bus.out_data), 32'(4'b0111));
      sync();
      drive(1'b0, 1'b0, '0, 1'b1);
      @(negedge clk);
      check("b2b_data_c", 32'(bus.out_data), 32'(4'b1101));
      check("b2b_valid_c", 32'(bus.out_valid), 32'd1);
      sync();
      @(negedge clk);
      check("b2b_drained", 32'(bus.out_valid), 32'd0);
      sync();

      // Saturation: five repeated codes on both counter widths.
      do_reset();
      xfer(1'b1, 4'b0000, 4'b0000, 1'b0, 0);
      for (int i = 0; i < 5; i++) xfer(1'b1, 4'b0000, 4'b0000, 1'b1, i + 1);
      @(negedge clk);
      check("sat_count_wide", 32'(bus.err_count), 32'd5);
      check("sat_count_narrow", 32'(bus2.err_count), 32'd3);
      sync();

      // Reset while a word is stalled in the output stage.
      drive(1'b1, 1'b1, 4'b0110, 1'b0);
      sync();
      drive(1'b0, 1'b0, '0, 1'b0);
      sync();
      rst_n = 1'b0;
      sync();
      rst_n = 1'b1;
      @(negedge clk);
      check("midrst_valid", 32'(bus.out_valid), 32'd0);
      check("midrst_count", 32'(bus.err_count), 32'd0);
      check("midrst_count_narrow", 32'(bus2.err_count), 32'd0);
      sync();
      xfer(1'b1, 4'b1111, 4'b1010, 1'b0, 0);

      repeat (2) sync();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
